predict_seq_ctrl: RTL
=====================

Name: predict_seq_ctrl

Overview:
- Sequencer for the fixed-topology MLP predict datapath: COLS inputs, HID hidden neurons, OUTS output neurons.
- Walks every test row, one hidden neuron and one weight at a time, driving addresses into the test-data and weight memories. It controls the shared 64-bit floating-point MAC through a req/ack handshake and strobes the writeback registers.
- Counts correct classifications and raises done (the acc_cal level the bench waits on) after the last row.

Parameters:
- ROWS, 100, number of test rows
- COLS, 15, features per row; hidden bias weight sits at index COLS
- HID, 10, hidden neurons; output bias weight sits at index HID
- OUTS, 2, output neurons
- DA_W, $clog2(ROWS*COLS), data address width
- WA_W, $clog2(HID*(COLS+1)+OUTS*(HID+1)), weight address width (182 entries -> 8)
- CNT_W, $clog2(ROWS+1), correct-count width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a full pass; sampled only in IDLE or DONE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level, high in DONE (acc_cal)
- data_addr  out  DA_W  row*COLS + j; valid in HID_MAC when j<COLS
- w_addr  out  WA_W  hidden: h*(COLS+1)+j; output: HID*(COLS+1)+o*(HID+1)+j
- mac_clr  out  1  one-cycle accumulator clear
- mac_req  out  1  MAC operation request
- mac_ack  in  1  MAC accepted the operands; may be high in the same cycle as mac_req
- mac_bias  out  1  input operand is 1.0 (j==COLS hidden, j==HID output)
- mac_src_hid  out  1  input operand comes from hidden register j rather than data memory
- hid_we  out  1  write activated accumulator into hidden register hid_idx
- hid_idx  out  $clog2(HID)  current hidden neuron h
- score_we  out  1  write accumulator into score register out_idx
- out_idx  out  $clog2(OUTS)  current output neuron o
- pred_cls  in  $clog2(OUTS)  argmax of score registers from the datapath; valid in CMP
- label  in  $clog2(OUTS)  expected class of the current row; valid in CMP
- row_idx  out  $clog2(ROWS)  current row
- correct_cnt  out  CNT_W  rows where pred_cls==label

Behaviour:
- Reset (asynchronous, any state, including mid-pass): state=IDLE; all outputs 0; counters row, h, o, j = 0.
- States: IDLE, HID_CLR, HID_MAC, HID_WB, OUT_CLR, OUT_MAC, OUT_WB, CMP, DONE.
- IDLE/DONE with start=1 -> HID_CLR. Clears row, h, o, j and correct_cnt. done drops in the same cycle busy rises.
- HID_CLR: mac_clr=1 for one cycle, j=0 -> HID_MAC.
- HID_MAC: mac_req=1. Addresses and mac_bias hold stable until mac_ack. On ack: if j==COLS -> HID_WB, else j++.
- HID_WB: hid_we=1 for one cycle. If h==HID-1: h=0, o=0 -> OUT_CLR; else h++ -> HID_CLR.
- OUT_CLR: mac_clr=1, j=0 -> OUT_MAC.
- OUT_MAC: mac_req=1, mac_src_hid=1. On ack: if j==HID -> OUT_WB, else j++.
- OUT_WB: score_we=1. If o==OUTS-1 -> CMP; else o++ -> OUT_CLR.
- CMP: one cycle; correct_cnt++ if pred_cls==label. If row==ROWS-1 -> DONE; else row++, h=0 -> HID_CLR.
- DONE: done=1 held; correct_cnt frozen until the next start.
- Handshake: mac_req is never dropped before mac_ack. The ack is ignored outside the MAC states. Wait cycles stall the FSM with no other effect.
- Latency with zero-wait ack (ack in the same cycle as req): ROWS*(HID*(COLS+3)+OUTS*(HID+3)+1) cycles from leaving IDLE to entering DONE. Defaults give 207 cycles per row and 20700 total.
- start while busy is ignored. start held high through DONE restarts the pass immediately.
- correct_cnt saturates at ROWS and never wraps.

Decomposition:
- Shared package predict_pkg: state enum, default topology constants, weight base offset OUT_W_BASE = HID*(COLS+1).
- One sub-module, predict_addr_gen: combinational data_addr/w_addr from row, h, o, j and the phase. Everything else lives in the FSM.

Test Plan:
- Reset mid-HID_MAC at row 1 -> all outputs 0 immediately; restart with start -> row_idx=0, correct_cnt=0.
- ROWS=2, COLS=3, HID=2, OUTS=2, zero-wait ack, label always equals pred_cls -> done 46 cycles after leaving IDLE, correct_cnt=2.
- Same config, label≠pred_cls on row 1 only -> correct_cnt=1.
- Random 0-3 cycle mac_ack delays -> addresses stable while req is pending. Address sequence: hidden h=1 w_addr 4..7; output o=1 w_addr 11..13; data_addr row*3+j.
- Defaults with the real weight file -> exactly 182 distinct w_addr values per row (0..181), 10 hid_we and 2 score_we pulses per row, done after 20700 zero-wait cycles.
- start pulsed while busy -> ignored; start pulsed in DONE -> done drops and the pass re-runs with identical counts.

Source files
------------

// File: rtl/predict_pkg.sv
// Shared types and default topology for the MLP predict sequencer.
package predict_pkg;

  localparam int unsigned ROWS_DEF = 100;
  localparam int unsigned COLS_DEF = 15;
  localparam int unsigned HID_DEF  = 10;
  localparam int unsigned OUTS_DEF = 2;

  localparam int unsigned OUT_W_BASE = HID_DEF * (COLS_DEF + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HID_CLR,
    ST_HID_MAC,
    ST_HID_WB,
    ST_OUT_CLR,
    ST_OUT_MAC,
    ST_OUT_WB,
    ST_CMP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_HID,
    PH_OUT
  } phase_e;

  function automatic int unsigned out_w_base(input int unsigned hid, input int unsigned cols);
    return hid * (cols + 1);
  endfunction

endpackage

// File: rtl/predict_seq_ctrl_if.sv
// MAC handshake, memory addresses and writeback strobes between sequencer and datapath.
interface predict_seq_ctrl_if #(
  parameter int unsigned DA_W  = 11,
  parameter int unsigned WA_W  = 8,
  parameter int unsigned HID_W = 4,
  parameter int unsigned OUT_W = 1
);
  logic [DA_W-1:0]  data_addr;
  logic [WA_W-1:0]  w_addr;
  logic             mac_clr;
  logic             mac_req;
  logic             mac_ack;
  logic             mac_bias;
  logic             mac_src_hid;
  logic             hid_we;
  logic [HID_W-1:0] hid_idx;
  logic             score_we;
  logic [OUT_W-1:0] out_idx;

  modport master (
    output data_addr, w_addr, mac_clr, mac_req, mac_bias, mac_src_hid,
           hid_we, hid_idx, score_we, out_idx,
    input  mac_ack
  );

  modport slave (
    input  data_addr, w_addr, mac_clr, mac_req, mac_bias, mac_src_hid,
           hid_we, hid_idx, score_we, out_idx,
    output mac_ack
  );
endinterface

// File: rtl/predict_addr_gen.sv
// Combinational test-data and weight address generation from loop counters.
module predict_addr_gen
  import predict_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned HID  = HID_DEF,
  parameter int unsigned DA_W = 11,
  parameter int unsigned WA_W = 8,
  parameter int unsigned RW   = 7,
  parameter int unsigned HW   = 4,
  parameter int unsigned OW   = 1,
  parameter int unsigned JW   = 4
) (
  input  phase_e          i_phase,
  input  logic [RW-1:0]   i_row,
  input  logic [HW-1:0]   i_h,
  input  logic [OW-1:0]   i_o,
  input  logic [JW-1:0]   i_j,
  output logic [DA_W-1:0] o_data_addr,
  output logic [WA_W-1:0] o_w_addr
);

  always_comb begin
    o_data_addr = '0;
    o_w_addr    = '0;
    unique case (i_phase)
      PH_HID: begin
        if (32'(i_j) < COLS)
          o_data_addr = DA_W'(32'(i_row) * COLS + 32'(i_j));
        o_w_addr = WA_W'(32'(i_h) * (COLS + 1) + 32'(i_j));
      end
      PH_OUT: o_w_addr = WA_W'(out_w_base(HID, COLS) + 32'(i_o) * (HID + 1) + 32'(i_j));
      default: ;
    endcase
  end

endmodule

// File: rtl/predict_seq_ctrl.sv
// Row/neuron/weight sequencer for the MLP predict datapath with MAC req/ack control.
module predict_seq_ctrl
  import predict_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned HID   = HID_DEF,
  parameter int unsigned OUTS  = OUTS_DEF,
  parameter int unsigned DA_W  = $clog2(ROWS * COLS),
  parameter int unsigned WA_W  = $clog2(HID * (COLS + 1) + OUTS * (HID + 1)),
  parameter int unsigned CNT_W = $clog2(ROWS + 1),
  parameter int unsigned RW    = $clog2(ROWS),
  parameter int unsigned HW    = $clog2(HID),
  parameter int unsigned OW    = $clog2(OUTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [OW-1:0]    pred_cls,
  input  logic [OW-1:0]    label,
  output logic [RW-1:0]    row_idx,
  output logic [CNT_W-1:0] correct_cnt,
  predict_seq_ctrl_if.master mac
);

  localparam int unsigned JW = $clog2(((COLS > HID) ? COLS : HID) + 1);

  state_e           r_state;
  logic [RW-1:0]    r_row;
  logic [HW-1:0]    r_h;
  logic [OW-1:0]    r_o;
  logic [JW-1:0]    r_j;
  logic [CNT_W-1:0] r_cnt;
  phase_e           w_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_h     <= '0;
      r_o     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_HID_CLR;
            r_row   <= '0;
            r_h     <= '0;
            r_o     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
          end
        end
        ST_HID_CLR: begin
          r_j     <= '0;
          r_state <= ST_HID_MAC;
        end
        ST_HID_MAC: begin
          if (mac.mac_ack) begin
            if (r_j == JW'(COLS)) r_state <= ST_HID_WB;
            else                  r_j     <= r_j + JW'(1);
          end
        end
        ST_HID_WB: begin
          if (r_h == HW'(HID - 1)) begin
            r_h     <= '0;
            r_o     <= '0;
            r_state <= ST_OUT_CLR;
          end else begin
            r_h     <= r_h + HW'(1);
            r_state <= ST_HID_CLR;
          end
        end
        ST_OUT_CLR: begin
          r_j     <= '0;
          r_state <= ST_OUT_MAC;
        end
        ST_OUT_MAC: begin
          if (mac.mac_ack) begin
            if (r_j == JW'(HID)) r_state <= ST_OUT_WB;
            else                 r_j     <= r_j + JW'(1);
          end
        end
        ST_OUT_WB: begin
          if (r_o == OW'(OUTS - 1)) begin
            r_state <= ST_CMP;
          end else begin
            r_o     <= r_o + OW'(1);
            r_state <= ST_OUT_CLR;
          end
        end
        ST_CMP: begin
          // Saturating: the count can never exceed ROWS in a single pass, but never wrap regardless.
          if (pred_cls == label && r_cnt != CNT_W'(ROWS))
            r_cnt <= r_cnt + CNT_W'(1);
          if (r_row == RW'(ROWS - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_row   <= r_row + RW'(1);
            r_h     <= '0;
            r_state <= ST_HID_CLR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy            = !(r_state == ST_IDLE || r_state == ST_DONE);
    done            = (r_state == ST_DONE);
    mac.mac_clr     = (r_state == ST_HID_CLR) || (r_state == ST_OUT_CLR);
    mac.mac_req     = (r_state == ST_HID_MAC) || (r_state == ST_OUT_MAC);
    mac.mac_src_hid = (r_state == ST_OUT_MAC);
    mac.mac_bias    = ((r_state == ST_HID_MAC) && (r_j == JW'(COLS))) ||
                      ((r_state == ST_OUT_MAC) && (r_j == JW'(HID)));
    mac.hid_we      = (r_state == ST_HID_WB);
    mac.score_we    = (r_state == ST_OUT_WB);
    mac.hid_idx     = r_h;
    mac.out_idx     = r_o;
    row_idx         = r_row;
    correct_cnt     = r_cnt;
    w_phase         = PH_NONE;
    if (r_state == ST_HID_MAC)      w_phase = PH_HID;
    else if (r_state == ST_OUT_MAC) w_phase = PH_OUT;
  end

  predict_addr_gen #(
    .COLS (COLS),
    .HID  (HID),
    .DA_W (DA_W),
    .WA_W (WA_W),
    .RW   (RW),
    .HW   (HW),
    .OW   (OW),
    .JW   (JW)
  ) u_addr_gen (
    .i_phase     (w_phase),
    .i_row       (r_row),
    .i_h         (r_h),
    .i_o         (r_o),
    .i_j         (r_j),
    .o_data_addr (mac.data_addr),
    .o_w_addr    (mac.w_addr)
  );

endmodule
